// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store initiator.
package mem_access_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_ALIGN = 2'b01,
    ERR_RANGE = 2'b10
  } err_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;
endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response bundle and DataMemory port bundle.
interface mem_access_req_if;
  logic        Req;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        Busy;
  logic        Done;
  logic [31:0] RdData;
  logic [1:0]  Err;

  modport master (output Req, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData,
                  input  Busy, Done, RdData, Err);
  modport slave  (input  Req, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData,
                  output Busy, Done, RdData, Err);
endinterface

interface mem_access_mem_if;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] MemReadData;

  modport master (output MemAddress, MemWriteData, MemWrite, MemRead,
                  input  MemReadData);
  modport slave  (input  MemAddress, MemWriteData, MemWrite, MemRead,
                  output MemReadData);
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic: alignment check, load extract/extend, sub-word store merge.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  chk_size,
  input  logic [1:0]  chk_lo,
  output logic        misaligned,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    // size code 3 falls into the word checks via >= SZ_WORD
    misaligned = ((chk_size == SZ_HALF) && chk_lo[0]) ||
                 ((chk_size >= SZ_WORD) && (chk_lo != 2'b00));

    byte_v = rdata[{lane, 3'b000} +: 8];
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];

    if (size >= SZ_WORD)
      load_data = rdata;
    else if (size == SZ_HALF)
      load_data = {{16{sgn & half_v[15]}}, half_v};
    else
      load_data = {{24{sgn & byte_v[7]}}, byte_v};

    merged = rdata;
    if (size == SZ_HALF) begin
      if (lane[1]) merged[31:16] = wdata;
      else         merged[15:0]  = wdata;
    end else if (size == SZ_BYTE) begin
      merged[{lane, 3'b000} +: 8] = wdata[7:0];
    end
  end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: word-aligned DataMemory access with sub-word
// extract/extend on loads and read-modify-write on sub-word stores.
//   state | meaning
//   IDLE  | waiting for Req; errors, reads or word writes dispatched from here
//   READ  | MemRead high, memory word sampled at the closing edge
//   WRITE | MemWrite high with full or merged word
//   RESP  | Done pulse, Err valid
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input logic             Clk,
  input logic             Reset,
  mem_access_req_if.slave  req,
  mem_access_mem_if.master mem
);
  localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

  state_e      state_q, state_d;
  err_e        err_q, err_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;

  logic        misaligned;
  logic        out_of_range;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic [31:0] word_addr;

  mem_lane_align u_align (
    .chk_size  (req.ReqSize),
    .chk_lo    (req.ReqAddr[1:0]),
    .misaligned(misaligned),
    .size      (size_q),
    .sgn       (sgn_q),
    .lane      (lane_q),
    .rdata     (mem.MemReadData),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  assign word_addr    = {req.ReqAddr[31:2], 2'b00};
  assign out_of_range = {2'b00, req.ReqAddr[31:2]} >= MEM_WORDS_U;

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    rd_data_d   = rd_data_q;
    done_d      = 1'b0;
    err_d       = ERR_NONE;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    unique case (state_q)
      IDLE: if (req.Req) begin
        wr_d    = req.ReqWrite;
        size_d  = req.ReqSize;
        sgn_d   = req.ReqSigned;
        lane_d  = req.ReqAddr[1:0];
        wdata_d = req.ReqWData[15:0];
        if (misaligned) begin
          state_d = RESP;
          done_d  = 1'b1;
          err_d   = ERR_ALIGN;
        end else if (out_of_range) begin
          state_d = RESP;
          done_d  = 1'b1;
          err_d   = ERR_RANGE;
        end else if (req.ReqWrite && (req.ReqSize >= SZ_WORD)) begin
          state_d     = WRITE;
          mem_write_d = 1'b1;
          mem_addr_d  = word_addr;
          mem_wdata_d = req.ReqWData;
        end else begin
          state_d    = READ;
          mem_read_d = 1'b1;
          mem_addr_d = word_addr;
        end
      end
      READ: begin
        if (wr_q) begin
          state_d     = WRITE;
          mem_write_d = 1'b1;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = merged;
        end else begin
          state_d   = RESP;
          done_d    = 1'b1;
          rd_data_d = load_data;
        end
      end
      WRITE: begin
        state_d = RESP;
        done_d  = 1'b1;
      end
      RESP: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Strobes are flops so an async Reset drops them immediately mid-access
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      err_q       <= ERR_NONE;
      wr_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      sgn_q       <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign req.Busy         = busy_q;
  assign req.Done         = done_q;
  assign req.RdData       = rd_data_q;
  assign req.Err          = err_q;
  assign mem.MemAddress   = mem_addr_q;
  assign mem.MemWriteData = mem_wdata_q;
  assign mem.MemRead      = mem_read_q;
  assign mem.MemWrite     = mem_write_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 1024-word behavioural DataMemory.
module tb_mem_access_unit;
  logic clk, rst;
  int vecs = 0;
  int errs = 0;

  logic [31:0] dmem [0:1023];
  logic        mem_ready = 1'b0;
  logic [31:0] last_load;

  int          o_done_cyc, o_rcnt, o_wcnt, o_rcyc, o_wcyc;
  logic [31:0] o_rd, o_raddr, o_waddr, o_wdata;
  logic [1:0]  o_err, o_err_after;
  logic        o_bad, o_busy_after, o_done_after;

  mem_access_req_if req_bus();
  mem_access_mem_if mem_bus();

  mem_access_unit #(.MEM_WORDS(1024)) dut (
    .Clk  (clk),
    .Reset(rst),
    .req  (req_bus),
    .mem  (mem_bus)
  );

  assign mem_bus.MemReadData = mem_bus.MemRead ? dmem[mem_bus.MemAddress[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= 32'h0;
      dmem[0]    <= 32'h11223344;
      dmem[1]    <= 32'h55667788;
      dmem[2]    <= 32'h8899AABB;
      dmem[3]    <= 32'hA5A5A5A5;
      dmem[1023] <= 32'hCAFEF00D;
      mem_ready  <= 1'b1;
    end else if (mem_bus.MemWrite) begin
      dmem[mem_bus.MemAddress[11:2]] <= mem_bus.MemWriteData;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Issues one request in the current IDLE cycle (cycle 0) and observes cycles
  // 1..done, then one trailing cycle.
  task automatic run_op(input bit w, input logic [1:0] sz, input bit s,
                        input logic [31:0] a, input logic [31:0] wd);
    o_done_cyc = -1; o_rcnt = 0; o_wcnt = 0; o_rcyc = -1; o_wcyc = -1;
    o_rd = 'x; o_raddr = 'x; o_waddr = 'x; o_wdata = 'x; o_err = 'x; o_bad = 1'b0;
    req_bus.Req = 1'b1; req_bus.ReqWrite = w; req_bus.ReqSize = sz;
    req_bus.ReqSigned = s; req_bus.ReqAddr = a; req_bus.ReqWData = wd;
    for (int k = 1; k <= 8 && o_done_cyc < 0; k++) begin
      @(posedge clk); #1;
      req_bus.Req = 1'b0;
      if (mem_bus.MemRead)  begin o_rcnt++; o_rcyc = k; o_raddr = mem_bus.MemAddress; end
      if (mem_bus.MemWrite) begin o_wcnt++; o_wcyc = k; o_waddr = mem_bus.MemAddress; o_wdata = mem_bus.MemWriteData; end
      if (mem_bus.MemRead && mem_bus.MemWrite) o_bad = 1'b1;
      if (!mem_bus.MemRead && !mem_bus.MemWrite &&
          (mem_bus.MemAddress != 0 || mem_bus.MemWriteData != 0)) o_bad = 1'b1;
      if (req_bus.Busy !== 1'b1) o_bad = 1'b1;
      if (!req_bus.Done && req_bus.Err != 2'b00) o_bad = 1'b1;
      if (req_bus.Done) begin o_done_cyc = k; o_rd = req_bus.RdData; o_err = req_bus.Err; end
    end
    @(posedge clk); #1;
    o_err_after = req_bus.Err; o_busy_after = req_bus.Busy; o_done_after = req_bus.Done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_bus.Req = 1'b0; req_bus.ReqWrite = 1'b0; req_bus.ReqSize = 2'd0;
    req_bus.ReqSigned = 1'b0; req_bus.ReqAddr = '0; req_bus.ReqWData = '0;
    #12;
    vecs++; if ({req_bus.Busy, req_bus.Done, mem_bus.MemRead, mem_bus.MemWrite} !== 4'b0000) begin errs++; $display("FAIL reset_strobes: got %b expected 0000", {req_bus.Busy, req_bus.Done, mem_bus.MemRead, mem_bus.MemWrite}); end
    vecs++; if (req_bus.RdData !== 32'h0 || req_bus.Err !== 2'b00) begin errs++; $display("FAIL reset_rd_err: got rd=%h err=%b expected 0/00", req_bus.RdData, req_bus.Err); end
    vecs++; if (mem_bus.MemAddress !== 32'h0 || mem_bus.MemWriteData !== 32'h0) begin errs++; $display("FAIL reset_bus: got addr=%h wdata=%h expected 0/0", mem_bus.MemAddress, mem_bus.MemWriteData); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    run_op(1'b0, 2'd2, 1'b0, 32'd8, 32'h0);
    vecs++; if (o_rcnt !== 1 || o_rcyc !== 1) begin errs++; $display("FAIL lw_read: got count=%0d cyc=%0d expected 1/1", o_rcnt, o_rcyc); end
    vecs++; if (o_raddr !== 32'd8) begin errs++; $display("FAIL lw_addr: got %h expected 00000008", o_raddr); end
    vecs++; if (o_done_cyc !== 2) begin errs++; $display("FAIL lw_latency: got %0d expected 2", o_done_cyc); end
    vecs++; if (o_rd !== 32'h8899AABB || o_err !== 2'b00) begin errs++; $display("FAIL lw_data: got rd=%h err=%b expected 8899aabb/00", o_rd, o_err); end
    vecs++; if (o_wcnt !== 0 || o_bad !== 1'b0) begin errs++; $display("FAIL lw_bus: got wcnt=%0d bad=%b expected 0/0", o_wcnt, o_bad); end
    vecs++; if ({o_busy_after, o_done_after, o_err_after} !== 4'b0000) begin errs++; $display("FAIL lw_after: got %b expected 0000", {o_busy_after, o_done_after, o_err_after}); end
    last_load = 32'h8899AABB;
  endtask

  task automatic test_sub_loads();
    logic [31:0] ta [8];
    logic [1:0]  tsz [8];
    logic        tsg [8];
    logic [31:0] texp [8];
    ta   = '{32'd9, 32'd9, 32'd10, 32'd10, 32'd11, 32'd8, 32'd8, 32'd8};
    tsz  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd3};
    tsg  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    texp = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899,
             32'hFFFFFF88, 32'h000000BB, 32'hFFFFAABB, 32'h8899AABB};
    for (int i = 0; i < 8; i++) begin
      run_op(1'b0, tsz[i], tsg[i], ta[i], 32'h0);
      vecs++; if (o_rd !== texp[i]) begin errs++; $display("FAIL subload_%0d_data: got %h expected %h", i, o_rd, texp[i]); end
      vecs++; if (o_done_cyc !== 2 || o_err !== 2'b00) begin errs++; $display("FAIL subload_%0d_done: got cyc=%0d err=%b expected 2/00", i, o_done_cyc, o_err); end
      vecs++; if (o_rcnt !== 1 || o_wcnt !== 0 || o_bad !== 1'b0) begin errs++; $display("FAIL subload_%0d_bus: got r=%0d w=%0d bad=%b expected 1/0/0", i, o_rcnt, o_wcnt, o_bad); end
      last_load = texp[i];
    end
  endtask

  task automatic test_stores();
    run_op(1'b1, 2'd0, 1'b0, 32'd11, 32'h12345677);
    vecs++; if (o_rcyc !== 1 || o_wcyc !== 2 || o_rcnt !== 1 || o_wcnt !== 1) begin errs++; $display("FAIL sb_phases: got r=%0d@%0d w=%0d@%0d expected 1@1 1@2", o_rcnt, o_rcyc, o_wcnt, o_wcyc); end
    vecs++; if (o_wdata !== 32'h7799AABB || o_waddr !== 32'd8) begin errs++; $display("FAIL sb_merge: got data=%h addr=%h expected 7799aabb/00000008", o_wdata, o_waddr); end
    vecs++; if (o_done_cyc !== 3 || o_err !== 2'b00 || o_bad !== 1'b0) begin errs++; $display("FAIL sb_done: got cyc=%0d err=%b bad=%b expected 3/00/0", o_done_cyc, o_err, o_bad); end
    vecs++; if (o_rd !== last_load) begin errs++; $display("FAIL sb_rd_hold: got %h expected %h", o_rd, last_load); end
    run_op(1'b0, 2'd2, 1'b0, 32'd8, 32'h0);
    vecs++; if (o_rd !== 32'h7799AABB) begin errs++; $display("FAIL sb_readback: got %h expected 7799aabb", o_rd); end
    last_load = 32'h7799AABB;
    run_op(1'b1, 2'd1, 1'b0, 32'd14, 32'h1234BEEF);
    vecs++; if (o_wdata !== 32'hBEEFA5A5 || o_done_cyc !== 3) begin errs++; $display("FAIL sh_merge: got data=%h cyc=%0d expected beefa5a5/3", o_wdata, o_done_cyc); end
    vecs++; if (dmem[3] !== 32'hBEEFA5A5) begin errs++; $display("FAIL sh_mem: got %h expected beefa5a5", dmem[3]); end
    run_op(1'b1, 2'd2, 1'b0, 32'd4, 32'hDEADBEEF);
    vecs++; if (o_rcnt !== 0 || o_wcyc !== 1 || o_done_cyc !== 2) begin errs++; $display("FAIL sw_timing: got r=%0d wcyc=%0d done=%0d expected 0/1/2", o_rcnt, o_wcyc, o_done_cyc); end
    vecs++; if (o_wdata !== 32'hDEADBEEF || dmem[1] !== 32'hDEADBEEF) begin errs++; $display("FAIL sw_data: got bus=%h mem=%h expected deadbeef", o_wdata, dmem[1]); end
    vecs++; if (o_rd !== last_load || o_bad !== 1'b0) begin errs++; $display("FAIL sw_rd_hold: got rd=%h bad=%b expected %h/0", o_rd, o_bad, last_load); end
  endtask

  task automatic test_errors();
    run_op(1'b0, 2'd1, 1'b1, 32'd9, 32'h0);
    vecs++; if (o_done_cyc !== 1 || o_err !== 2'b01) begin errs++; $display("FAIL lh_mis: got cyc=%0d err=%b expected 1/01", o_done_cyc, o_err); end
    vecs++; if (o_rcnt !== 0 || o_wcnt !== 0 || o_rd !== last_load) begin errs++; $display("FAIL lh_mis_side: got r=%0d w=%0d rd=%h expected 0/0/%h", o_rcnt, o_wcnt, o_rd, last_load); end
    vecs++; if (o_err_after !== 2'b00) begin errs++; $display("FAIL err_clear: got %b expected 00", o_err_after); end
    run_op(1'b1, 2'd2, 1'b0, 32'd4096, 32'h0BADF00D);
    vecs++; if (o_done_cyc !== 1 || o_err !== 2'b10) begin errs++; $display("FAIL sw_range: got cyc=%0d err=%b expected 1/10", o_done_cyc, o_err); end
    vecs++; if (o_rcnt !== 0 || o_wcnt !== 0 || o_rd !== last_load || o_bad !== 1'b0) begin errs++; $display("FAIL sw_range_side: got r=%0d w=%0d rd=%h bad=%b", o_rcnt, o_wcnt, o_rd, o_bad); end
    run_op(1'b0, 2'd2, 1'b0, 32'h1002, 32'h0);
    vecs++; if (o_err !== 2'b01) begin errs++; $display("FAIL err_priority: got %b expected 01", o_err); end
    run_op(1'b1, 2'd0, 1'b0, 32'd4096, 32'h000000FF);
    vecs++; if (o_err !== 2'b10 || o_wcnt !== 0) begin errs++; $display("FAIL sb_range: got err=%b w=%0d expected 10/0", o_err, o_wcnt); end
    run_op(1'b0, 2'd2, 1'b0, 32'd4092, 32'h0);
    vecs++; if (o_err !== 2'b00 || o_rd !== 32'hCAFEF00D) begin errs++; $display("FAIL last_word: got err=%b rd=%h expected 00/cafef00d", o_err, o_rd); end
    last_load = 32'hCAFEF00D;
  endtask

  task automatic test_reset_mid_write();
    int ndone;
    req_bus.Req = 1'b1; req_bus.ReqWrite = 1'b1; req_bus.ReqSize = 2'd1;
    req_bus.ReqSigned = 1'b0; req_bus.ReqAddr = 32'd8; req_bus.ReqWData = 32'h0000CAFE;
    @(posedge clk); #1;
    req_bus.Req = 1'b0;
    @(posedge clk); #1;
    vecs++; if (mem_bus.MemWrite !== 1'b1 || mem_bus.MemWriteData !== 32'h7799CAFE) begin errs++; $display("FAIL rst_pre: got we=%b data=%h expected 1/7799cafe", mem_bus.MemWrite, mem_bus.MemWriteData); end
    #2 rst = 1'b1;
    #1;
    vecs++; if (mem_bus.MemWrite !== 1'b0 || mem_bus.MemRead !== 1'b0) begin errs++; $display("FAIL rst_async: got we=%b re=%b expected 0/0", mem_bus.MemWrite, mem_bus.MemRead); end
    vecs++; if ({req_bus.Busy, req_bus.Done, req_bus.Err} !== 4'b0000 || req_bus.RdData !== 32'h0) begin errs++; $display("FAIL rst_outs: got busy=%b done=%b err=%b rd=%h expected 0", req_bus.Busy, req_bus.Done, req_bus.Err, req_bus.RdData); end
    vecs++; if (mem_bus.MemAddress !== 32'h0 || mem_bus.MemWriteData !== 32'h0) begin errs++; $display("FAIL rst_bus: got addr=%h data=%h expected 0/0", mem_bus.MemAddress, mem_bus.MemWriteData); end
    @(posedge clk); #1;
    vecs++; if (dmem[2] !== 32'h7799AABB) begin errs++; $display("FAIL rst_mem: got %h expected 7799aabb", dmem[2]); end
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (req_bus.Done) ndone++;
    end
    vecs++; if (ndone !== 0) begin errs++; $display("FAIL rst_no_done: got %0d expected 0", ndone); end
    run_op(1'b0, 2'd2, 1'b0, 32'd8, 32'h0);
    vecs++; if (o_rd !== 32'h7799AABB) begin errs++; $display("FAIL rst_readback: got %h expected 7799aabb", o_rd); end
  endtask

  task automatic test_back_to_back();
    int ndone, d1, d2;
    logic [31:0] rd1, rd2, raddr4;
    ndone = 0; d1 = -1; d2 = -1; rd1 = 'x; rd2 = 'x; raddr4 = 'x;
    req_bus.Req = 1'b1; req_bus.ReqWrite = 1'b0; req_bus.ReqSize = 2'd2;
    req_bus.ReqSigned = 1'b0; req_bus.ReqAddr = 32'd0; req_bus.ReqWData = 32'h0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) req_bus.ReqAddr = 32'd4;
      if (k == 4) req_bus.Req = 1'b0;
      if (k == 4 && mem_bus.MemRead) raddr4 = mem_bus.MemAddress;
      if (req_bus.Done) begin
        ndone++;
        if (d1 < 0) begin d1 = k; rd1 = req_bus.RdData; end
        else begin d2 = k; rd2 = req_bus.RdData; end
      end
    end
    vecs++; if (ndone !== 2) begin errs++; $display("FAIL b2b_count: got %0d expected 2", ndone); end
    vecs++; if (d1 !== 2 || d2 !== 5) begin errs++; $display("FAIL b2b_timing: got %0d,%0d expected 2,5", d1, d2); end
    vecs++; if (rd1 !== 32'h11223344 || rd2 !== 32'hDEADBEEF) begin errs++; $display("FAIL b2b_data: got %h,%h expected 11223344,deadbeef", rd1, rd2); end
    vecs++; if (raddr4 !== 32'd4) begin errs++; $display("FAIL b2b_addr: got %h expected 00000004", raddr4); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sub_loads();
    test_stores();
    test_errors();
    test_reset_mid_write();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store initiator that drives the DataMemory port (Address, WriteData, MemWrite, MemRead, ReadData) on behalf of the MEM pipeline stage. It accepts byte, halfword and word load/store requests. It aligns addresses to words, sign- or zero-extends loads, and performs read-modify-write for sub-word stores. Sits between the EX/MEM register and DataMemory, with a Busy/Done handshake towards the pipeline.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in DataMemory; word index >= MEM_WORDS is out of range

Ports:
Clk  in  1  system clock, rising-edge
Reset  in  1  asynchronous, active-high reset
Req  in  1  request strobe; sampled only in IDLE
ReqWrite  in  1  1 = store, 0 = load
ReqSize  in  2  0 = byte, 1 = half, 2 = word (3 is treated as word)
ReqSigned  in  1  loads only: 1 = sign-extend, 0 = zero-extend
ReqAddr  in  32  byte address
ReqWData  in  32  store data, low bits used for sub-word stores
Busy  out  1  high in every non-IDLE state
Done  out  1  one-cycle completion pulse
RdData  out  32  load result, registered
Err  out  2  00 ok, 01 misaligned, 10 out of range; valid only with Done
MemAddress  out  32  word-aligned address {ReqAddr[31:2],2'b00}
MemWriteData  out  32  full word to write
MemWrite  out  1  memory write enable
MemRead  out  1  memory read enable
MemReadData  in  32  DataMemory ReadData (combinational, valid while MemRead=1)

Behaviour:
- One clock (Clk); reset is asynchronous and active-high (Reset).
- Reset values: state IDLE; Busy, Done, MemWrite, MemRead = 0; RdData, Err, MemAddress, MemWriteData = 0.
- Reset mid-operation: MemWrite and MemRead drop immediately (asynchronously). Any in-flight write is aborted and no Done is issued.
- Request capture in IDLE when Req=1: latch ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData. Req is ignored while Busy.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Checked before range; misaligned takes priority.
- Out of range: addr[31:2] >= MEM_WORDS.
- FSM states (Moore memory strobes):
  - IDLE: no request -> IDLE. Error -> RESP with Err set. Word store -> WRITE. Load or sub-word store -> READ.
  - READ: MemRead=1. Word register <= MemReadData at the edge. Load -> RESP; sub-word store -> WRITE.
  - WRITE: MemWrite=1, MemWriteData = ReqWData (word) or merged word (sub-word) -> RESP.
  - RESP: Done=1 for one cycle; Err holds the code; -> IDLE.
- Latency from the accept edge, where cycle 0 is the IDLE cycle with Req=1:
  - lw/lb/lh: Done in cycle 2.
  - sw: Done in cycle 2.
  - sb/sh: Done in cycle 3.
  - Error: Done in cycle 1, with no MemRead or MemWrite ever asserted.
- Byte lanes are little-endian: byte k = bits[8k+7:8k], k = addr[1:0]; half h = bits[16h+15:16h], h = addr[1].
- Merge: only the addressed lane(s) are replaced with ReqWData[7:0] or [15:0]; the other lanes keep the value read in READ.
- RdData updates only on load completion with no error. It holds otherwise, including across stores and errors.
- Err returns to 00 in the cycle after RESP.
- MemAddress and MemWriteData are 0 when both strobes are low.
- MemRead and MemWrite are never high together.

Decomposition:
- Package mem_access_pkg:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD
  - error codes ERR_NONE/ERR_ALIGN/ERR_RANGE
  - FSM state encodings IDLE/READ/WRITE/RESP
- Sub-module mem_lane_align: purely combinational. It holds the load extract and extend path, the store lane merge, and the alignment check. Instantiated once.

Test Plan:
(Preload word address 8 = 0x8899AABB.)
1. lw addr 8:
   - MemRead=1 for exactly one cycle with MemAddress=8.
   - Done in cycle 2; RdData=0x8899AABB; Err=00.
2. lb addr 9 signed -> 0xFFFFFFAA; lbu addr 9 -> 0x000000AA; lh addr 10 signed -> 0xFFFF8899; lhu addr 10 -> 0x00008899.
3. sb addr 11, ReqWData=0x12345677:
   - READ in cycle 1, then WRITE in cycle 2 with MemWriteData=0x7799AABB.
   - Done in cycle 3; a following lw 8 returns 0x7799AABB.
4. Error cases:
   - lh addr 9 -> Done in cycle 1, Err=01, no memory strobes.
   - sw addr 4096 (MEM_WORDS=1024) -> Err=10, memory untouched.
   - RdData unchanged in both cases.
5. Reset during WRITE of an sh to addr 8:
   - MemWrite falls asynchronously; no Done is issued.
   - Word 8 is unchanged; Busy=0; all outputs 0.
6. Req held high across two back-to-back lw (addr 0, then 4):
   - The second request is accepted only in the IDLE cycle after RESP.
   - Exactly two Done pulses, 3 cycles apart.
